pipe_credit_fifo: RTL and testbench
===================================

Name: pipe_credit_fifo

Overview:
- Elastic buffer directly downstream of the fixed-latency, non-stallable `pipe` delay line.
- Items leave `pipe` unconditionally LATENCY cycles after issue, so this block tracks in-flight items as credits. It tells the issuer when it may launch another item, guaranteeing every item emerging from the pipe finds a free slot.
- Downstream consumers (rasterizer / framebuffer writer) drain it with a valid/ready handshake.

Parameters:
- WIDTH, 16, data bits per item.
- DEPTH, 16, FIFO entries; power of two, >= 2.
- LATENCY, 10, cycles from issue to arrival at in_valid; informational (drives an assertion only).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- issue  input  1  upstream launched one item into the pipe this cycle.
- can_issue  output  1  issuing this cycle is safe.
- in_valid  input  1  item arriving from pipe output.
- in_data  input  WIDTH  arriving item payload.
- out_valid  output  1  FIFO non-empty (first-word-fall-through).
- out_data  output  WIDTH  head-of-FIFO payload.
- out_ready  input  1  consumer accepts head when out_valid.
- count  output  $clog2(DEPTH)+1  entries currently stored.
- inflight  output  $clog2(DEPTH)+1  issued items not yet arrived.
- err_overflow  output  1  sticky: arrival dropped because FIFO full.
- err_underflow  output  1  sticky: in_valid with inflight==0, or issue while !can_issue.

Behaviour:
- Reset (async assert, sync release):
  - count=0, inflight=0, rd/wr pointers=0.
  - out_valid=0, can_issue=1, err flags=0.
  - Memory contents are not reset.
- can_issue = (count + inflight) < DEPTH. Combinational from registered state only; no path from issue, in_valid or out_ready.
- Pop: pop = out_valid & out_ready. Head advances next cycle.
- Push: push = in_valid & (count<DEPTH | pop). A push in the same cycle as a pop on a full FIFO is accepted.
- Dropped arrival: in_valid with count==DEPTH and no pop → item dropped, err_overflow set.
- count_next = count + push - pop.
- inflight:
  - +1 on issue, -1 on in_valid; both in one cycle → unchanged.
  - in_valid with inflight==0 → inflight stays 0, err_underflow set; the item is still pushed if space.
  - issue while !can_issue → err_underflow set; inflight still increments, saturating at DEPTH.
- Pointers wrap modulo DEPTH.
- out_valid = (count != 0); out_data = mem[rd_ptr]. No bypass: an item pushed in cycle N is visible at cycle N+1.
- Latency: push to out_valid is 1 cycle. Issue to out_valid is LATENCY+1 cycles when empty.
- Error flags clear only on rst.
- Reset mid-operation: all state returns to reset values immediately. Items still in the pipe at reset deassertion will raise err_underflow on arrival; the system must reset the pipe and this block together.
- Simulation-only assertion: the inflight==0 arrival case never occurs when issue is driven only while can_issue is high.

Test Plan:
- Reset then idle 5 cycles → can_issue=1, out_valid=0, count=0, inflight=0, errors 0.
- Single issue at cycle 0 through `pipe` LENGTH=10, in_data=0xABCD, out_ready=1:
  - inflight=1 for cycles 1–10.
  - push at cycle 10, out_valid=1 with out_data=0xABCD at cycle 11.
  - pop in cycle 11, count returns to 0.
- Back-pressure: out_ready=0, issue every cycle while can_issue:
  - exactly 16 issues occur; can_issue falls at cycle 16.
  - after arrivals count=16, inflight=0, err_overflow=0.
- Drain-refill: from full, out_ready=1 for 4 cycles → count=12. can_issue reasserts the cycle after the first pop; 4 more issues allowed before it drops again.
- Full with simultaneous pop and push → count stays 16, no overflow. Payload order preserved across pointer wrap (sequence 0..39 read back in order).
- Protocol errors:
  - forcing in_valid with inflight==0 → err_underflow=1, sticky until rst.
  - forcing in_valid on full FIFO with out_ready=0 → err_overflow=1, count stays 16.

Source files
------------

// File: rtl/pipe_credit_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : pipe_credit_fifo_if
// Description : Issue/arrival/drain handshake bundle for pipe_credit_fifo.
// Revision    : 1.0 - initial release
// ============================================================================
interface pipe_credit_fifo_if #(
  parameter int WIDTH = 16
) ();
  logic             issue;
  logic             can_issue;
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;

  // slave = the FIFO itself; master = issuer, pipe output and consumer
  modport slave (
    input  issue, in_valid, in_data, out_ready,
    output can_issue, out_valid, out_data
  );

  modport master (
    output issue, in_valid, in_data, out_ready,
    input  can_issue, out_valid, out_data
  );
endinterface
`default_nettype wire

// File: rtl/pipe_credit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : pipe_credit_fifo
// Description : Credit-tracked elastic FIFO behind a fixed-latency pipe.
// Revision    : 1.0 - initial release
// ============================================================================
module pipe_credit_fifo #(
  parameter int WIDTH   = 16,
  parameter int DEPTH   = 16,
  parameter int LATENCY = 10
) (
  input  logic                    clk,
  input  logic                    rst,
  pipe_credit_fifo_if.slave       bus,
  output logic [$clog2(DEPTH):0]  count,
  output logic [$clog2(DEPTH):0]  inflight,
  output logic                    err_overflow,
  output logic                    err_underflow
);
  localparam int c_aw = $clog2(DEPTH);
  localparam int c_cw = c_aw + 1;
  localparam logic [c_cw-1:0] c_full = c_cw'(DEPTH);

  logic [c_cw-1:0]  count_q, count_d;
  logic [c_cw-1:0]  inflight_q, inflight_d;
  logic [c_aw-1:0]  rd_ptr_q, rd_ptr_d;
  logic [c_aw-1:0]  wr_ptr_q, wr_ptr_d;
  logic             err_ovf_q, err_ovf_d;
  logic             err_unf_q, err_unf_d;
  logic [WIDTH-1:0] mem [DEPTH];

  logic             w_full;
  logic             w_pop;
  logic             w_push;
  logic             w_credit_ok;
  logic             w_arrive_credit;
  logic [c_cw:0]    w_committed;

  always_comb begin
    // Slots already promised: stored items plus items still in the pipe.
    w_committed     = {1'b0, count_q} + {1'b0, inflight_q};
    w_credit_ok     = w_committed < (c_cw + 1)'(DEPTH);
    w_full          = (count_q == c_full);
    w_pop           = (count_q != '0) && bus.out_ready;
    w_push          = bus.in_valid && (!w_full || w_pop);
    w_arrive_credit = bus.in_valid && (inflight_q != '0);

    count_d  = count_q + c_cw'(w_push) - c_cw'(w_pop);
    rd_ptr_d = rd_ptr_q + c_aw'(w_pop);
    wr_ptr_d = wr_ptr_q + c_aw'(w_push);

    inflight_d = inflight_q;
    if (bus.issue && !w_arrive_credit) begin
      inflight_d = (inflight_q == c_full) ? c_full : inflight_q + 1'b1;
    end else if (!bus.issue && w_arrive_credit) begin
      inflight_d = inflight_q - 1'b1;
    end

    err_ovf_d = err_ovf_q | (bus.in_valid & w_full & ~w_pop);
    err_unf_d = err_unf_q | (bus.in_valid & (inflight_q == '0))
                          | (bus.issue & ~w_credit_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q    <= '0;
      inflight_q <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
      err_ovf_q  <= 1'b0;
      err_unf_q  <= 1'b0;
    end else begin
      count_q    <= count_d;
      inflight_q <= inflight_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
      err_ovf_q  <= err_ovf_d;
      err_unf_q  <= err_unf_d;
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_push) begin
      mem[wr_ptr_q] <= bus.in_data;
    end
  end

  assign bus.can_issue  = w_credit_ok;
  assign bus.out_valid  = (count_q != '0);
  assign bus.out_data   = mem[rd_ptr_q];
  assign count          = count_q;
  assign inflight       = inflight_q;
  assign err_overflow   = err_ovf_q;
  assign err_underflow  = err_unf_q;

`ifndef SYNTHESIS
  // Shadow of the pipe: while every arrival matches an issue LATENCY cycles
  // earlier and no issue broke credit, an arrival must always hold a credit.
  logic [LATENCY-1:0] hist_q, hist_d;
  logic               sane_q, sane_d;

  always_comb begin
    hist_d = (hist_q << 1) | LATENCY'(bus.issue);
    sane_d = sane_q && (bus.in_valid == hist_q[LATENCY-1])
                    && !(bus.issue && !w_credit_ok);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hist_q <= '0;
      sane_q <= 1'b1;
    end else begin
      hist_q <= hist_d;
      sane_q <= sane_d;
    end
  end

  a_arrival_has_credit : assert property (
    @(posedge clk) disable iff (rst) (sane_d && bus.in_valid) |-> (inflight_q != '0)
  ) else $error("pipe arrival with no credit outstanding");
`endif

endmodule
`default_nettype wire

// File: tb/tb_pipe_credit_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_pipe_credit_fifo
// Description : Randomized bench for pipe_credit_fifo against a queue model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pipe_credit_fifo;
  localparam int WIDTH   = 16;
  localparam int DEPTH   = 16;
  localparam int LATENCY = 10;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pipe_credit_fifo_if #(.WIDTH(WIDTH)) bus ();
  logic [4:0] count;
  logic [4:0] inflight;
  logic       err_overflow;
  logic       err_underflow;

  pipe_credit_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .LATENCY(LATENCY)) dut (
    .clk           (clk),
    .rst           (rst),
    .bus           (bus),
    .count         (count),
    .inflight      (inflight),
    .err_overflow  (err_overflow),
    .err_underflow (err_underflow)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: stored items as a queue, credits as a plain integer.
  logic [WIDTH-1:0] m_q [$];
  int               m_inf;
  bit               m_ovf;
  bit               m_unf;
  // The fixed-latency pipe that feeds the block.
  bit               pv [LATENCY];
  logic [WIDTH-1:0] pd [LATENCY];

  function automatic bit m_can();
    return (m_q.size() + m_inf) < DEPTH;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic check_all();
    check("count", 32'(count), 32'(m_q.size()));
    check("inflight", 32'(inflight), 32'(m_inf));
    check("can_issue", 32'(bus.can_issue), 32'(m_can()));
    check("out_valid", 32'(bus.out_valid), 32'(m_q.size() != 0));
    if (m_q.size() != 0) check("out_data", 32'(bus.out_data), 32'(m_q[0]));
    check("err_overflow", 32'(err_overflow), 32'(m_ovf));
    check("err_underflow", 32'(err_underflow), 32'(m_unf));
  endtask

  // One clock: drive inputs, advance the model, then compare after the edge.
  task automatic step(input bit iss, input bit rdy, input bit frc, input logic [WIDTH-1:0] d);
    bit               iv;
    bit               pop;
    bit               push;
    logic [WIDTH-1:0] idat;
    iv   = pv[LATENCY-1] | frc;
    idat = frc ? d : pd[LATENCY-1];
    bus.issue     = iss;
    bus.in_valid  = iv;
    bus.in_data   = idat;
    bus.out_ready = rdy;
    pop  = (m_q.size() != 0) && rdy;
    push = iv && ((m_q.size() < DEPTH) || pop);
    if (iv && !push) m_ovf = 1'b1;
    if (iv && m_inf == 0) m_unf = 1'b1;
    if (iss && !m_can()) m_unf = 1'b1;
    m_inf = m_inf + int'(iss) - ((iv && m_inf > 0) ? 1 : 0);
    if (m_inf > DEPTH) m_inf = DEPTH;
    if (pop) void'(m_q.pop_front());
    if (push) m_q.push_back(idat);
    for (int j = LATENCY - 1; j > 0; j--) begin
      pv[j] = pv[j-1];
      pd[j] = pd[j-1];
    end
    pv[0] = iss;
    pd[0] = d;
    @(posedge clk);
    #1;
    check_all();
  endtask

  // Asserted between edges to exercise the asynchronous path; pipe is left alone.
  task automatic do_reset();
    bus.issue     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    rst = 1'b1;
    #1;
    m_q.delete();
    m_inf = 0;
    m_ovf = 1'b0;
    m_unf = 1'b0;
    check_all();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int n_iss;
    int seq;
    int rd;
    bit go;
    bit r;

    for (int j = 0; j < LATENCY; j++) begin
      pv[j] = 1'b0;
      pd[j] = '0;
    end
    do_reset();
    repeat (5) step(1'b0, 1'b0, 1'b0, '0);
    check("idle_can_issue", 32'(bus.can_issue), 32'd1);
    check("idle_out_valid", 32'(bus.out_valid), 32'd0);

    // Single item through the pipe.
    step(1'b1, 1'b1, 1'b0, 16'hABCD);
    for (int c = 1; c <= 10; c++) begin
      check("single_inflight", 32'(inflight), 32'd1);
      step(1'b0, 1'b1, 1'b0, '0);
    end
    check("single_out_valid", 32'(bus.out_valid), 32'd1);
    check("single_out_data", 32'(bus.out_data), 32'hABCD);
    step(1'b0, 1'b1, 1'b0, '0);
    check("single_drained", 32'(count), 32'd0);

    // Back-pressure: credits cap issues at DEPTH.
    n_iss = 0;
    for (int c = 0; c < 20; c++) begin
      go = m_can();
      n_iss += int'(go);
      step(go, 1'b0, 1'b0, 16'(c));
      if (c == 15) check("bp_can_issue_c16", 32'(bus.can_issue), 32'd0);
    end
    check("bp_issue_total", 32'(n_iss), 32'd16);
    repeat (LATENCY) step(1'b0, 1'b0, 1'b0, '0);
    check("bp_count", 32'(count), 32'd16);
    check("bp_inflight", 32'(inflight), 32'd0);
    check("bp_no_overflow", 32'(err_overflow), 32'd0);

    // Drain four, then refill exactly four.
    step(1'b0, 1'b1, 1'b0, '0);
    check("drain_can_issue", 32'(bus.can_issue), 32'd1);
    repeat (3) step(1'b0, 1'b1, 1'b0, '0);
    check("drain_count", 32'(count), 32'd12);
    n_iss = 0;
    for (int c = 0; c < 8; c++) begin
      go = m_can();
      n_iss += int'(go);
      step(go, 1'b0, 1'b0, 16'(200 + c));
    end
    check("refill_issues", 32'(n_iss), 32'd4);
    repeat (LATENCY + 1) step(1'b0, 1'b0, 1'b0, '0);
    check("refill_count", 32'(count), 32'd16);

    // Ordering across pointer wrap: 0..39 must come out in sequence.
    do_reset();
    seq = 0;
    rd  = 0;
    for (int c = 0; c < 600 && rd < 40; c++) begin
      go = m_can() && (seq < 40) && ($urandom_range(0, 3) != 0);
      r  = ($urandom_range(0, 2) != 0);
      if (r && m_q.size() != 0) begin
        check("order", 32'(bus.out_data), 32'(rd));
        rd++;
      end
      step(go, r, 1'b0, 16'(seq));
      if (go) seq++;
    end
    check("order_complete", 32'(rd), 32'd40);

    // Fill, then push+pop on full, then a genuine overflow.
    for (int c = 0; c < 80 && !(m_q.size() == DEPTH && m_inf == 0); c++)
      step(m_can(), 1'b0, 1'b0, 16'(300 + c));
    check("full_count", 32'(count), 32'd16);
    step(1'b0, 1'b1, 1'b1, 16'h5A5A);
    check("full_pushpop_count", 32'(count), 32'd16);
    check("full_pushpop_no_ovf", 32'(err_overflow), 32'd0);
    check("unf_on_stray_arrival", 32'(err_underflow), 32'd1);
    step(1'b0, 1'b0, 1'b1, 16'hDEAD);
    check("ovf_set", 32'(err_overflow), 32'd1);
    check("ovf_count_held", 32'(count), 32'd16);
    repeat (3) step(1'b0, 1'b1, 1'b0, '0);
    check("ovf_sticky", 32'(err_overflow), 32'd1);
    check("unf_sticky", 32'(err_underflow), 32'd1);
    do_reset();
    check("ovf_cleared", 32'(err_overflow), 32'd0);
    check("unf_cleared", 32'(err_underflow), 32'd0);

    // Random legal traffic with a reset while items are still in the pipe.
    for (int c = 0; c < 400; c++) begin
      if (c == 200) do_reset();
      go = m_can() && ($urandom_range(0, 1) != 0);
      r  = ($urandom_range(0, 3) != 0);
      step(go, r, 1'b0, 16'($urandom));
    end

    // Issue regardless of credit: inflight saturates, underflow latches.
    for (int c = 0; c < 40; c++)
      step(1'b1, ($urandom_range(0, 3) == 0), 1'b0, 16'($urandom));
    repeat (LATENCY + 2) step(1'b0, 1'b1, 1'b0, '0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
`default_nettype wire
